// File: rtl/sobel_line_buffer_if.sv
// -----------------------------------------------------------------------------
// sobel_line_buffer_if
//   Groups the two first-word-fall-through FIFO handshakes around the Sobel
//   line buffer.
//
//   Input FIFO side (pixels in):
//     fifo_in_rd_en   pop the head pixel this cycle
//     fifo_in_dout    head pixel, valid whenever fifo_in_empty = 0
//     fifo_in_empty   input FIFO has no data
//   Output FIFO side (column words out):
//     fifo_out_wr_en  push fifo_out_din this cycle
//     fifo_out_din    column word {row r, row r-1, row r-2}
//     fifo_out_full   output FIFO cannot take a word
//
//   Modports:
//     slave   the line buffer itself (pops the input FIFO, pushes the output)
//     master  the FIFO environment around it
// -----------------------------------------------------------------------------
interface sobel_line_buffer_if #(
    parameter int DWIDTH_IN  = 8,
    parameter int DWIDTH_OUT = 24
) ();

    logic                  fifo_in_rd_en;
    logic [DWIDTH_IN-1:0]  fifo_in_dout;
    logic                  fifo_in_empty;

    logic                  fifo_out_wr_en;
    logic [DWIDTH_OUT-1:0] fifo_out_din;
    logic                  fifo_out_full;

    modport slave (
        output fifo_in_rd_en,
        input  fifo_in_dout,
        input  fifo_in_empty,
        output fifo_out_wr_en,
        output fifo_out_din,
        input  fifo_out_full
    );

    modport master (
        input  fifo_in_rd_en,
        output fifo_in_dout,
        output fifo_in_empty,
        input  fifo_out_wr_en,
        input  fifo_out_din,
        output fifo_out_full
    );

endinterface

// File: rtl/sobel_line_buffer.sv
// -----------------------------------------------------------------------------
// sobel_line_buffer
//   Turns a raster-order grayscale pixel stream into column words of three
//   vertically adjacent pixels for the Sobel stage.  The two previous rows are
//   kept in two line memories; one word is produced per pixel column once the
//   first two rows of a frame have been seen.
//
//   Ports:
//     clock       single clock, all state updates on the rising edge
//     reset       asynchronous, active-low
//     bus         FIFO handshakes (slave modport of sobel_line_buffer_if)
//                   fifo_in_*  : pixel source (first-word-fall-through)
//                   fifo_out_* : column-word sink (first-word-fall-through)
//     frame_done  one-cycle pulse the cycle after the last word of a frame
//                 has been pushed
//
//   Word layout: [3*DW-1:2*DW] row r, [2*DW-1:DW] row r-1, [DW-1:0] row r-2.
// -----------------------------------------------------------------------------
module sobel_line_buffer #(
    parameter int WIDTH      = 720,
    parameter int HEIGHT     = 540,
    parameter int DWIDTH_IN  = 8,
    parameter int DWIDTH_OUT = 24
) (
    input  logic              clock,
    input  logic              reset,
    sobel_line_buffer_if.slave bus,
    output logic              frame_done
);

    localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    // Line memories: lb0 holds row r-2, lb1 holds row r-1 (not reset; the
    // first two rows of every frame overwrite them before they are used).
    logic [DWIDTH_IN-1:0]  r_lb0 [WIDTH];
    logic [DWIDTH_IN-1:0]  r_lb1 [WIDTH];

    logic [COL_W-1:0]      r_col_p0;
    logic [ROW_W-1:0]      r_row_p0;

    logic                  r_vld_p1;
    logic [DWIDTH_OUT-1:0] r_data_p1;
    logic                  r_last_p1;
    logic                  r_frame_done;

    logic                  w_push;
    logic                  w_accept;
    logic                  w_col_last;
    logic                  w_row_last;
    logic                  w_row_ge2;
    logic [DWIDTH_IN-1:0]  w_pix;
    logic [DWIDTH_IN-1:0]  w_above1;
    logic [DWIDTH_IN-1:0]  w_above2;
    logic [DWIDTH_OUT-1:0] w_word;

    // ---- stage p0: pixel accept, line-memory read, raster counters ----

    // A new pixel can be taken whenever the output register is free or is
    // being emptied this same cycle, which gives one word per cycle.
    assign w_push   = r_vld_p1 & ~bus.fifo_out_full;
    assign w_accept = ~bus.fifo_in_empty & (~r_vld_p1 | ~bus.fifo_out_full);

    assign bus.fifo_in_rd_en  = w_accept;
    assign bus.fifo_out_wr_en = w_push;
    assign bus.fifo_out_din   = r_data_p1;
    assign frame_done         = r_frame_done;

    assign w_pix      = bus.fifo_in_dout;
    assign w_above1   = r_lb1[r_col_p0];
    assign w_above2   = r_lb0[r_col_p0];
    assign w_word     = {w_pix, w_above1, w_above2};

    assign w_col_last = (r_col_p0 == COL_LAST);
    assign w_row_last = (r_row_p0 == ROW_LAST);
    // Rows 0 and 1 of a frame only prime the line memories.
    assign w_row_ge2  = (32'(r_row_p0) >= 32'd2);

    // Each column shifts up by one row: r-1 becomes r-2, the new pixel
    // becomes r-1.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_lb0[r_col_p0] <= w_above1;
            r_lb1[r_col_p0] <= w_pix;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_col_p0 <= '0;
            r_row_p0 <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col_p0 <= '0;
                r_row_p0 <= w_row_last ? '0 : r_row_p0 + ROW_W'(1);
            end else begin
                r_col_p0 <= r_col_p0 + COL_W'(1);
            end
        end
    end

    // ---- stage p1: output word register and end-of-frame flag ----

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vld_p1     <= 1'b0;
            r_data_p1    <= '0;
            r_last_p1    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_accept && w_row_ge2) begin
                r_vld_p1  <= 1'b1;
                r_data_p1 <= w_word;
                // Marks the word built from the final pixel of the frame so
                // that its push can raise frame_done.
                r_last_p1 <= w_col_last & w_row_last;
            end else if (w_push) begin
                r_vld_p1  <= 1'b0;
            end
            r_frame_done <= w_push & r_last_p1;
        end
    end

endmodule

// File: tb/tb_sobel_line_buffer.sv
module tb_sobel_line_buffer;

    localparam int W = 4;
    localparam int H = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic frame_done;

    sobel_line_buffer_if #(.DWIDTH_IN(8), .DWIDTH_OUT(24)) bus ();

    sobel_line_buffer #(
        .WIDTH(W), .HEIGHT(H), .DWIDTH_IN(8), .DWIDTH_OUT(24)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          scn;
        int          idx;
        logic [23:0] word;
    } vec_t;

    vec_t        vecs [6];

    int          n_checks = 0;
    int          n_err    = 0;

    logic [7:0]  in_q  [$];
    logic [23:0] exp_q [$];
    logic [23:0] got   [$];

    int cyc = 0;
    int n_acc, fd_count, fd_cyc, first_push_acc, first_push_cyc, last_push_cyc, both_cnt;
    int empty_mode = 0;
    int full_mode  = 0;
    int stall_left = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic start_scn();
        got.delete();
        exp_q.delete();
        n_acc = 0; fd_count = 0; fd_cyc = -1; both_cnt = 0;
        first_push_acc = -1; first_push_cyc = -1; last_push_cyc = -1;
    endtask

    // Reference: a frame is a 2-D array; every row from 2 on yields one word
    // per column stacking that row over the two rows above it.
    task automatic load_frame(input logic [7:0] base, input bit rnd);
        logic [7:0] img [H][W];
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                img[r][c] = rnd ? 8'($urandom) : base + 8'(r * 16 + c);
                in_q.push_back(img[r][c]);
            end
        for (int r = 2; r < H; r++)
            for (int c = 0; c < W; c++)
                exp_q.push_back({img[r][c], img[r-1][c], img[r-2][c]});
    endtask

    // One clock: drive FIFO-side inputs after the falling edge, then sample
    // the handshake that will take effect on the next rising edge.
    task automatic cycle();
        bit          e, f;
        logic        rd, wr;
        logic [23:0] din;
        @(negedge clock);
        cyc++;
        case (empty_mode)
            1:       e = cyc[0];
            2:       e = ($urandom_range(0, 2) == 0);
            default: e = 1'b0;
        endcase
        e = e || (in_q.size() == 0);
        f = 1'b0;
        if (full_mode == 2) begin
            f = ($urandom_range(0, 3) == 0);
        end else if (full_mode == 1 && n_acc >= 9 && stall_left > 0) begin
            f = 1'b1;
            stall_left--;
        end
        bus.fifo_in_empty = e;
        bus.fifo_in_dout  = (in_q.size() != 0) ? in_q[0] : 8'h00;
        bus.fifo_out_full = f;
        #1;
        rd  = bus.fifo_in_rd_en;
        wr  = bus.fifo_out_wr_en;
        din = bus.fifo_out_din;
        if (frame_done) begin
            fd_count++;
            fd_cyc = cyc;
        end
        if (e) chk("rd_en_while_empty", 32'(rd), 0);
        if (f) chk("wr_en_while_full", 32'(wr), 0);
        if (f && full_mode == 1) begin
            chk("rd_en_during_stall", 32'(rd), 0);
            chk("din_held_during_stall", 32'(din), 32'h201000);
        end
        if (rd && wr) both_cnt++;
        if (wr) begin
            if (got.size() == 0) begin
                first_push_acc = n_acc;
                first_push_cyc = cyc;
            end
            last_push_cyc = cyc;
            got.push_back(din);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_word: got %0h, expected no push", din);
            end else begin
                chk("word", 32'(din), 32'(exp_q.pop_front()));
            end
        end
        if (rd) begin
            void'(in_q.pop_front());
            n_acc++;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        if (in_q.size() != 0 || exp_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pixels / %0d words left, expected 0",
                     in_q.size(), exp_q.size());
        end
        repeat (4) cycle();
    endtask

    task automatic run_until_acc(input int target);
        int n = 0;
        while (n_acc < target && n < 100) begin
            cycle();
            n++;
        end
        chk("accept_count", 32'(n_acc), 32'(target));
    endtask

    task automatic check_table(input int scn);
        foreach (vecs[i]) begin
            if (vecs[i].scn == scn) begin
                if (vecs[i].idx < got.size())
                    chk($sformatf("table_s%0d_w%0d", scn, vecs[i].idx),
                        32'(got[vecs[i].idx]), 32'(vecs[i].word));
                else
                    chk($sformatf("table_s%0d_w%0d_present", scn, vecs[i].idx), 0, 1);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1, 0,  24'h201000};
        vecs[1] = '{1, 3,  24'h231303};
        vecs[2] = '{1, 7,  24'h332313};
        vecs[3] = '{5, 7,  24'h332313};
        vecs[4] = '{5, 8,  24'hA09080};
        vecs[5] = '{5, 15, 24'hB3A393};

        // Reset state
        bus.fifo_in_empty = 1'b1;
        bus.fifo_in_dout  = 8'h00;
        bus.fifo_out_full = 1'b0;
        #12;
        chk("reset_wr_en", 32'(bus.fifo_out_wr_en), 0);
        chk("reset_rd_en", 32'(bus.fifo_in_rd_en), 0);
        chk("reset_din", 32'(bus.fifo_out_din), 0);
        chk("reset_frame_done", 32'(frame_done), 0);
        @(negedge clock);
        reset = 1'b1;

        // 1: free-running frame
        start_scn();
        load_frame(8'h00, 1'b0);
        drain(200);
        chk("s1_word_count", 32'(got.size()), 8);
        chk("s1_first_push_after_pixel_0_2", 32'(first_push_acc), 9);
        chk("s1_frame_done_count", 32'(fd_count), 1);
        chk("s1_frame_done_timing", 32'(fd_cyc), 32'(last_push_cyc + 1));
        chk("s1_push_with_accept", 32'(both_cnt), 7);
        chk("s1_burst_span", 32'(last_push_cyc - first_push_cyc), 7);
        check_table(1);

        // 2: output stall on the first valid word
        start_scn();
        full_mode  = 1;
        stall_left = 5;
        load_frame(8'h00, 1'b0);
        drain(200);
        full_mode = 0;
        chk("s2_stall_cycles_used", 32'(stall_left), 0);
        chk("s2_word_count", 32'(got.size()), 8);
        chk("s2_frame_done_count", 32'(fd_count), 1);

        // 3: input gaps every other cycle
        start_scn();
        empty_mode = 1;
        load_frame(8'h00, 1'b0);
        drain(200);
        empty_mode = 0;
        chk("s3_word_count", 32'(got.size()), 8);
        chk("s3_frame_done_count", 32'(fd_count), 1);

        // 4a: asynchronous reset after 6 pixels
        start_scn();
        for (int i = 0; i < 6; i++) in_q.push_back(8'((i / W) * 16 + (i % W)));
        run_until_acc(6);
        @(negedge clock);
        bus.fifo_in_empty = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rstA_wr_en", 32'(bus.fifo_out_wr_en), 0);
        chk("rstA_rd_en", 32'(bus.fifo_in_rd_en), 0);
        chk("rstA_din", 32'(bus.fifo_out_din), 0);
        chk("rstA_frame_done", 32'(frame_done), 0);
        @(negedge clock);
        reset = 1'b1;
        start_scn();
        load_frame(8'h00, 1'b0);
        drain(200);
        chk("s4a_word_count", 32'(got.size()), 8);
        chk("s4a_frame_done_count", 32'(fd_count), 1);

        // 4b: asynchronous reset while a word is pending
        start_scn();
        for (int i = 0; i < 9; i++) in_q.push_back(8'((i / W) * 16 + (i % W)));
        run_until_acc(9);
        @(negedge clock);
        bus.fifo_in_empty = 1'b1;
        bus.fifo_out_full = 1'b1;
        #1;
        chk("rstB_pending_din", 32'(bus.fifo_out_din), 32'h201000);
        bus.fifo_out_full = 1'b0;
        #1;
        chk("rstB_pending_wr_en", 32'(bus.fifo_out_wr_en), 1);
        #1 reset = 1'b0;
        #1;
        chk("rstB_wr_en_dropped", 32'(bus.fifo_out_wr_en), 0);
        chk("rstB_din_cleared", 32'(bus.fifo_out_din), 0);
        @(negedge clock);
        reset = 1'b1;
        start_scn();
        load_frame(8'h00, 1'b0);
        drain(200);
        chk("s4b_word_count", 32'(got.size()), 8);
        chk("s4b_frame_done_count", 32'(fd_count), 1);

        // 5: two back-to-back frames
        start_scn();
        load_frame(8'h00, 1'b0);
        load_frame(8'h80, 1'b0);
        drain(300);
        chk("s5_word_count", 32'(got.size()), 16);
        chk("s5_frame_done_count", 32'(fd_count), 2);
        check_table(5);

        // Randomised frames with random gaps and backpressure
        start_scn();
        empty_mode = 2;
        full_mode  = 2;
        for (int f = 0; f < 3; f++) load_frame(8'h00, 1'b1);
        drain(3000);
        empty_mode = 0;
        full_mode  = 0;
        chk("rand_word_count", 32'(got.size()), 24);
        chk("rand_frame_done_count", 32'(fd_count), 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
